// File: rtl/dense_sequencer_pkg.sv
// Shared types and helpers for the Dense layer sequencer.
// State encoding and counter-width helper used by the top and its testbench.
package dense_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_BIAS,
        S_WRITE,
        S_DONE
    } state_t;

    // Counter width for a count of n; a count of 1 still gets one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_sequencer_strobe_delay.sv
// Fixed-depth strobe delay line for the Dense sequencer.
// Async active-low reset, synchronous clear that flushes all stages.
module strobe_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    // Shift the strobe one stage per cycle; clr drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/dense_sequencer.sv
// Control FSM for the Dense fully-connected layer.
// Walks neurons and inputs, issuing RAM addresses and latency-aligned MAC strobes.
module dense_sequencer
    import dense_sequencer_pkg::*;
#(
    parameter int IN_COUNT  = 10,
    parameter int OUT_COUNT = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    output logic                                  busy,
    output logic                                  done,
    output logic [cw(IN_COUNT)-1:0]               in_adr,
    output logic [cw(IN_COUNT*OUT_COUNT)-1:0]     weight_adr,
    output logic [cw(OUT_COUNT)-1:0]              bias_adr,
    output logic                                  acc_clr,
    output logic                                  mac_en,
    output logic                                  bias_en,
    output logic [cw(OUT_COUNT)-1:0]              out_adr,
    output logic                                  out_wr
);

    localparam int IW = cw(IN_COUNT);
    localparam int WW = cw(IN_COUNT * OUT_COUNT);
    localparam int OW = cw(OUT_COUNT);
    localparam int DW = cw(RD_LAT);

    localparam logic [IW-1:0] I_LAST = IW'(IN_COUNT - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_COUNT - 1);
    localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

    state_t        state;
    state_t        nxt;
    logic [IW-1:0] i_cnt;
    logic [OW-1:0] o_cnt;
    logic [WW-1:0] w_cnt;
    logic [DW-1:0] d_cnt;
    logic          issue;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state decode; abort overrides everything, including start.
    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start) nxt = S_ISSUE;
                S_ISSUE: if (i_cnt == I_LAST) nxt = S_DRAIN;
                S_DRAIN: if (d_cnt == D_LAST) nxt = S_BIAS;
                S_BIAS:  nxt = S_WRITE;
                S_WRITE: nxt = (o_cnt == O_LAST) ? S_DONE : S_ISSUE;
                S_DONE:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Address counters; the weight address only ever increments, carrying across neurons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            o_cnt <= '0;
            w_cnt <= '0;
            d_cnt <= '0;
        end else if (abort) begin
            d_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        i_cnt <= '0;
                        o_cnt <= '0;
                        w_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    if (i_cnt != I_LAST) begin
                        i_cnt <= i_cnt + 1'b1;
                        w_cnt <= w_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    d_cnt <= (d_cnt == D_LAST) ? '0 : d_cnt + 1'b1;
                end
                S_WRITE: begin
                    if (o_cnt != O_LAST) begin
                        o_cnt <= o_cnt + 1'b1;
                        i_cnt <= '0;
                        w_cnt <= w_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered strobes, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_clr <= 1'b0;
            bias_en <= 1'b0;
            out_wr  <= 1'b0;
            done    <= 1'b0;
        end else begin
            acc_clr <= (nxt == S_ISSUE) && (state != S_ISSUE);
            bias_en <= (nxt == S_BIAS);
            out_wr  <= (nxt == S_WRITE);
            done    <= (nxt == S_DONE);
        end
    end

    assign issue = (state == S_ISSUE);

    strobe_delay #(
        .DEPTH(RD_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .d     (issue),
        .q     (mac_en)
    );

    assign busy       = (state != S_IDLE);
    assign in_adr     = i_cnt;
    assign weight_adr = w_cnt;
    assign bias_adr   = o_cnt;
    assign out_adr    = o_cnt;

endmodule
